key_event_ctrl: RTL and testbench

Sequencer between the PS/2 byte receiver and the scan-code-to-ASCII converter. Decodes make/break/extended prefixes, tracks Shift and Caps Lock to drive the converter's letter-case select, and suppresses typematic repeats. Presents each translated key press as one ASCII byte through a single-entry valid/ready output buffer to the game logic.

---
 rtl/key_event_ctrl.sv | 165 ++++++++++++++++
 tb/tb_key_event_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// PS/2 key event sequencer: decodes make/break/extended prefixes, tracks Shift/Caps,
// suppresses typematic repeats and hands translated ASCII to a 1-entry valid/ready buffer.
module key_event_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter bit          REPEAT_EN      = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] conv_scan_code,
  output logic       letter_case,
  input  logic [7:0] conv_ascii,
  output logic [7:0] out_ascii,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StBrk    = 3'd1;
  localparam logic [2:0] StExt    = 3'd2;
  localparam logic [2:0] StExtBrk = 3'd3;
  localparam logic [2:0] StLookup = 3'd4;

  localparam logic [7:0] CodeBrk    = 8'hF0;
  localparam logic [7:0] CodeExt    = 8'hE0;
  localparam logic [7:0] CodeShiftL = 8'h12;
  localparam logic [7:0] CodeShiftR = 8'h59;
  localparam logic [7:0] CodeCaps   = 8'h58;

  logic [2:0]    state_q, state_d;
  logic          shift_l_q, shift_l_d, shift_r_q, shift_r_d, caps_q, caps_d;
  logic          letter_case_q, letter_case_d;
  logic [7:0]    last_make_q, last_make_d, code_q, code_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    pend_code_q, pend_code_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    out_ascii_q, out_ascii_d;
  logic          out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic          byte_avail;
  logic [7:0]    byte_in;

  // A buffered byte always takes precedence over the live strobe.
  assign byte_avail = pend_valid_q | scan_valid;
  assign byte_in    = pend_valid_q ? pend_code_q : scan_code;

  always_comb begin
    state_d     = state_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    caps_d      = caps_q;
    last_make_d = last_make_q;
    code_d      = code_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    tmo_d       = tmo_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_ascii_d = out_ascii_q;
    overrun_d   = 1'b0;

    if (state_q == StLookup) begin
      if (scan_valid) begin
        pend_valid_d = 1'b1;
        pend_code_d  = scan_code;
      end
      if (conv_ascii != 8'h00) begin
        if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b1;
          out_ascii_d = conv_ascii;
        end else begin
          overrun_d = 1'b1;
        end
      end
      state_d = StIdle;
    end else begin
      if (pend_valid_q) begin
        pend_valid_d = scan_valid;
        if (scan_valid) pend_code_d = scan_code;
      end
      if (byte_avail) begin
        tmo_d = '0;
        case (state_q)
          StIdle: begin
            if (byte_in == CodeBrk) begin
              state_d = StBrk;
            end else if (byte_in == CodeExt) begin
              state_d = StExt;
            end else if (byte_in == CodeShiftL) begin
              shift_l_d = 1'b1;
            end else if (byte_in == CodeShiftR) begin
              shift_r_d = 1'b1;
            end else if (byte_in == CodeCaps) begin
              caps_d = ~caps_q;
            end else if (REPEAT_EN || (byte_in != last_make_q)) begin
              code_d      = byte_in;
              last_make_d = byte_in;
              state_d     = StLookup;
            end
          end
          StBrk: begin
            if (byte_in == CodeShiftL) shift_l_d = 1'b0;
            if (byte_in == CodeShiftR) shift_r_d = 1'b0;
            if (byte_in == last_make_q) last_make_d = 8'h00;
            state_d = StIdle;
          end
          StExt:   state_d = (byte_in == CodeBrk) ? StExtBrk : StIdle;
          default: state_d = StIdle;
        endcase
      end else if (state_q != StIdle) begin
        // Abandon a dangling prefix so a lost break byte cannot swallow the next key.
        if (tmo_q == TmoLast) begin
          state_d = StIdle;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    end

    letter_case_d = (shift_l_d | shift_r_d) ^ caps_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      shift_l_q     <= 1'b0;
      shift_r_q     <= 1'b0;
      caps_q        <= 1'b0;
      letter_case_q <= 1'b0;
      last_make_q   <= 8'h00;
      code_q        <= 8'h00;
      pend_valid_q  <= 1'b0;
      pend_code_q   <= 8'h00;
      tmo_q         <= '0;
      out_ascii_q   <= 8'h00;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_l_q     <= shift_l_d;
      shift_r_q     <= shift_r_d;
      caps_q        <= caps_d;
      letter_case_q <= letter_case_d;
      last_make_q   <= last_make_d;
      code_q        <= code_d;
      pend_valid_q  <= pend_valid_d;
      pend_code_q   <= pend_code_d;
      tmo_q         <= tmo_d;
      out_ascii_q   <= out_ascii_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign conv_scan_code = code_q;
  assign letter_case    = letter_case_q;
  assign out_ascii      = out_ascii_q;
  assign out_valid      = out_valid_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: event-level reference model checked every cycle, plus
// directed scenarios with hand-computed expectations on a REPEAT_EN=0 and a REPEAT_EN=1 copy.
module tb_key_event_ctrl;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       out_ready = 1'b1;

  logic [7:0] conv_scan_code0, conv_ascii0, out_ascii0;
  logic       letter_case0, out_valid0, overrun0;
  logic [7:0] conv_scan_code1, conv_ascii1, out_ascii1;
  logic       letter_case1, out_valid1, overrun1;

  int checks = 0;
  int failures = 0;
  int hs0 = 0, hs1 = 0, ovc0 = 0;

  always #5 clk = ~clk;

  // Stand-in for the scan-code-to-ASCII converter.
  function automatic logic [7:0] conv_fn(input logic [7:0] c, input logic up);
    case (c)
      8'h16:   return 8'h31;
      8'h1E:   return 8'h32;
      8'h26:   return 8'h33;
      8'h45:   return 8'h30;
      8'h44:   return up ? 8'h4F : 8'h6F;
      8'h22:   return up ? 8'h58 : 8'h78;
      8'h1C:   return up ? 8'h41 : 8'h61;
      default: return 8'h00;
    endcase
  endfunction

  assign conv_ascii0 = conv_fn(conv_scan_code0, letter_case0);
  assign conv_ascii1 = conv_fn(conv_scan_code1, letter_case1);

  key_event_ctrl #(.TIMEOUT_CYCLES(T), .REPEAT_EN(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
    .conv_scan_code(conv_scan_code0), .letter_case(letter_case0), .conv_ascii(conv_ascii0),
    .out_ascii(out_ascii0), .out_valid(out_valid0), .out_ready(out_ready), .overrun(overrun0)
  );

  key_event_ctrl #(.TIMEOUT_CYCLES(T), .REPEAT_EN(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
    .conv_scan_code(conv_scan_code1), .letter_case(letter_case1), .conv_ascii(conv_ascii1),
    .out_ascii(out_ascii1), .out_valid(out_valid1), .out_ready(out_ready), .overrun(overrun1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for dut0: key semantics (prefix mode, held modifiers, last key)
  // plus a queue of bytes waiting while a lookup is in flight.
  int         m_mode = 0;  // 0 none, 1 after F0, 2 after E0, 3 after E0 F0
  int         m_idle = 0;
  bit         m_lkp = 0, m_shl = 0, m_shr = 0, m_caps = 0, m_case = 0, m_ov = 0, m_ovr = 0;
  logic [7:0] m_code = 8'h00, m_last = 8'h00, m_oa = 8'h00;
  logic [7:0] m_pend[$];

  initial begin : model
    logic [7:0] b, ch;
    bit have, nl;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_mode = 0; m_idle = 0; m_lkp = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_case = 0;
        m_ov = 0; m_ovr = 0; m_code = 8'h00; m_last = 8'h00; m_oa = 8'h00;
        m_pend.delete();
      end else begin
        if (m_ov && out_ready) hs0++;
        if (out_valid1 && out_ready) hs1++;
        ch = conv_fn(m_code, m_case);
        m_ovr = 0;
        if (m_lkp && ch != 8'h00 && (!m_ov || out_ready)) begin
          m_ov = 1; m_oa = ch;
        end else begin
          if (m_lkp && ch != 8'h00) m_ovr = 1;
          if (m_ov && out_ready) m_ov = 0;
        end
        nl = 0;
        have = 0;
        b = 8'h00;
        if (m_lkp) begin
          if (scan_valid) begin m_pend.delete(); m_pend.push_back(scan_code); end
        end else begin
          if (m_pend.size() > 0) begin
            b = m_pend.pop_front(); have = 1;
            if (scan_valid) m_pend.push_back(scan_code);
          end else if (scan_valid) begin
            b = scan_code; have = 1;
          end
          if (have) begin
            m_idle = 0;
            if (m_mode == 0) begin
              if (b == 8'hF0) m_mode = 1;
              else if (b == 8'hE0) m_mode = 2;
              else if (b == 8'h12) m_shl = 1;
              else if (b == 8'h59) m_shr = 1;
              else if (b == 8'h58) m_caps = !m_caps;
              else if (b != m_last) begin m_code = b; m_last = b; nl = 1; end
            end else if (m_mode == 1) begin
              if (b == 8'h12) m_shl = 0;
              if (b == 8'h59) m_shr = 0;
              if (b == m_last) m_last = 8'h00;
              m_mode = 0;
            end else begin
              m_mode = (m_mode == 2 && b == 8'hF0) ? 3 : 0;
            end
          end else if (m_mode != 0) begin
            m_idle++;
            if (m_idle == T) begin m_mode = 0; m_idle = 0; end
          end
        end
        m_lkp = nl;
        m_case = (m_shl || m_shr) != m_caps;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (overrun0) ovc0++;
      chk("out_valid", 32'(out_valid0), 32'(m_ov));
      chk("out_ascii", 32'(out_ascii0), 32'(m_oa));
      chk("overrun", 32'(overrun0), 32'(m_ovr));
      chk("letter_case", 32'(letter_case0), 32'(m_case));
      chk("conv_scan_code", 32'(conv_scan_code0), 32'(m_code));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic strobe(input logic [7:0] b);
    scan_code = b; scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int h0, h1, o0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid0), 32'h0);
    chk("rst_out_ascii", 32'(out_ascii0), 32'h0);
    chk("rst_letter_case", 32'(letter_case0), 32'h0);
    chk("rst_conv_scan_code", 32'(conv_scan_code0), 32'h0);
    chk("rst_overrun", 32'(overrun0), 32'h0);
    resetn = 1'b1;
    idle(1);

    // Basic latency: strobe in N, LOOKUP in N+1, valid in N+2 only.
    strobe(8'h16);
    @(negedge clk); chk("lat_n1_valid", 32'(out_valid0), 32'h0);
    @(negedge clk); chk("lat_n2_valid", 32'(out_valid0), 32'h1);
    chk("lat_n2_ascii", 32'(out_ascii0), 32'h31);
    @(negedge clk); chk("lat_n3_valid", 32'(out_valid0), 32'h0);
    idle(1);

    // Typematic repeat suppression vs pass-through.
    h0 = hs0; h1 = hs1;
    strobe(8'h44); idle(2); strobe(8'h44); idle(2); strobe(8'h44); idle(2);
    strobe(8'hF0); idle(2); strobe(8'h44); idle(2); strobe(8'h44); idle(4);
    chk("repeat_off_count", 32'(hs0 - h0), 32'd2);
    chk("repeat_on_count", 32'(hs1 - h1), 32'd4);
    chk("repeat_ascii", 32'(out_ascii0), 32'h6F);

    // Shift then caps.
    strobe(8'h12); strobe(8'h22);
    @(negedge clk); chk("shift_case_lookup1", 32'(letter_case0), 32'h1);
    @(negedge clk); chk("shift_ascii", 32'(out_ascii0), 32'h58);
    idle(1);
    strobe(8'hF0); strobe(8'h22); strobe(8'hF0); strobe(8'h12); strobe(8'h22);
    @(negedge clk); chk("shift_case_lookup2", 32'(letter_case0), 32'h0);
    @(negedge clk); chk("unshift_ascii", 32'(out_ascii0), 32'h78);
    idle(1);
    strobe(8'h58);
    @(negedge clk); chk("caps_case", 32'(letter_case0), 32'h1);
    idle(1);
    strobe(8'h1C); idle(3);
    chk("caps_ascii", 32'(out_ascii0), 32'h41);
    strobe(8'h58); idle(2);

    // Extended keys are never translated.
    h0 = hs0;
    strobe(8'hE0); idle(1); strobe(8'h75); idle(1);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h75); idle(1);
    strobe(8'h45); idle(4);
    chk("ext_count", 32'(hs0 - h0), 32'd1);
    chk("ext_ascii", 32'(out_ascii0), 32'h30);

    // Prefix timeout: byte just inside the window is a break, after expiry is a make.
    h0 = hs0;
    strobe(8'hF0); idle(T - 2); strobe(8'h1E); idle(4);
    chk("tmo_inside_count", 32'(hs0 - h0), 32'd0);
    strobe(8'hF0); idle(T + 1); strobe(8'h1E); idle(3);
    chk("tmo_after_count", 32'(hs0 - h0), 32'd1);
    chk("tmo_after_ascii", 32'(out_ascii0), 32'h32);

    // Overrun while the consumer stalls.
    out_ready = 1'b0;
    o0 = ovc0;
    strobe(8'h16); idle(2); strobe(8'h1E); idle(3);
    chk("ovr_valid", 32'(out_valid0), 32'h1);
    chk("ovr_ascii_hold", 32'(out_ascii0), 32'h31);
    chk("ovr_pulses", 32'(ovc0 - o0), 32'd1);
    // Handshake and reload on the same edge.
    strobe(8'h1C);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("reload_valid", 32'(out_valid0), 32'h1);
    chk("reload_ascii", 32'(out_ascii0), 32'h61);
    chk("reload_no_ovr", 32'(ovc0 - o0), 32'd1);
    idle(2);

    // Byte landing during LOOKUP goes through the pending slot.
    strobe(8'h16); strobe(8'h26);
    @(negedge clk); chk("pend_first", 32'(out_ascii0), 32'h31);
    @(negedge clk); chk("pend_gap_valid", 32'(out_valid0), 32'h0);
    @(negedge clk); chk("pend_second_valid", 32'(out_valid0), 32'h1);
    chk("pend_second_ascii", 32'(out_ascii0), 32'h33);
    idle(1);

    // Asynchronous reset in the middle of a break sequence.
    out_ready = 1'b0;
    strobe(8'h58); strobe(8'h16); idle(3);
    strobe(8'hF0); idle(1);
    resetn = 1'b0;
    #2;
    chk("mid_rst_out_valid", 32'(out_valid0), 32'h0);
    chk("mid_rst_out_ascii", 32'(out_ascii0), 32'h0);
    chk("mid_rst_letter_case", 32'(letter_case0), 32'h0);
    chk("mid_rst_conv_scan_code", 32'(conv_scan_code0), 32'h0);
    chk("mid_rst_overrun", 32'(overrun0), 32'h0);
    idle(1);
    resetn = 1'b1;
    out_ready = 1'b1;
    idle(1);
    strobe(8'h1E); idle(3);
    chk("post_rst_ascii", 32'(out_ascii0), 32'h32);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
